// File: rtl/decode_regfile_sb.sv
// decode_regfile_sb: register file with a per-register in-flight scoreboard and write-to-read bypass.
// Optional feature macro RF_BYPASS_EN: forward same-cycle writeback data and clear pending on read ports.
module decode_regfile_sb #(
  parameter int WIDTH  = 16,
  parameter int NREG   = 8,
  parameter int NRD    = 2,
  parameter int MAXINF = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NRD*$clog2(NREG)-1:0]   rd_sel,
  input  logic [NRD-1:0]                rd_en,
  output logic [NRD*WIDTH-1:0]          rd_data,
  output logic [NRD-1:0]                rd_pending,
  input  logic                          alloc_en,
  input  logic [$clog2(NREG)-1:0]       alloc_reg,
  output logic                          alloc_ready,
  input  logic                          wb_en,
  input  logic [$clog2(NREG)-1:0]       wb_reg,
  input  logic [WIDTH-1:0]              wb_data,
  input  logic                          flush,
  output logic                          stall,
  output logic                          err
);

  localparam int AW = $clog2(NREG);
  localparam int CW = 3;

  logic [WIDTH-1:0] regs [NREG];
  logic [CW-1:0]    cnt  [NREG];
  logic [NREG-1:0]  inc_v;
  logic [NREG-1:0]  dec_v;

  // alloc_en/alloc_ready: an allocation is taken on every edge where alloc_en is high;
  // alloc_ready is advisory, and allocating while it is low is recorded in err, not counted.
  assign alloc_ready = (cnt[alloc_reg] < CW'(MAXINF));
  assign inc_v       = alloc_en ? (NREG'(1) << alloc_reg) : '0;
  assign dec_v       = wb_en    ? (NREG'(1) << wb_reg)    : '0;
  assign stall       = |(rd_en & rd_pending);

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0] sel;
    logic          byp;
    logic          same_alloc;

    assign sel = rd_sel[gi*AW +: AW];
`ifdef RF_BYPASS_EN
    assign byp = wb_en & (wb_reg == sel);
`else
    assign byp = 1'b0;
`endif
    assign same_alloc = alloc_en & (alloc_reg == sel);
    assign rd_data[gi*WIDTH +: WIDTH] = byp ? wb_data : regs[sel];
    // A last outstanding writeback arriving now resolves the operand, unless a new one is issued.
    assign rd_pending[gi] = (cnt[sel] != '0) &
                            ~(byp & (cnt[sel] == CW'(1)) & ~same_alloc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
    end else begin
      if (wb_en) regs[wb_reg] <= wb_data;
      for (int r = 0; r < NREG; r++) begin
        if (flush) begin
          // Squash drops every count and any concurrent decrement; a concurrent issue survives.
          cnt[r] <= inc_v[r] ? CW'(1) : '0;
        end else if (inc_v[r] && !dec_v[r]) begin
          if (cnt[r] == CW'(MAXINF)) err <= 1'b1;
          else                        cnt[r] <= cnt[r] + CW'(1);
        end else if (dec_v[r] && !inc_v[r]) begin
          if (cnt[r] == '0) err <= 1'b1;
          else              cnt[r] <= cnt[r] - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_decode_regfile_sb.sv
// Bench for decode_regfile_sb: directed scenarios plus randomized traffic against a transaction-level model.
// Follows RF_BYPASS_EN the same way the design does.
module tb_decode_regfile_sb;

  localparam int WIDTH  = 16;
  localparam int NREG   = 8;
  localparam int NRD    = 2;
  localparam int MAXINF = 3;
  localparam int AW     = 3;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                   clk;
  logic                   rst;
  logic [NRD*AW-1:0]      rd_sel;
  logic [NRD-1:0]         rd_en;
  logic [NRD*WIDTH-1:0]   rd_data;
  logic [NRD-1:0]         rd_pending;
  logic                   alloc_en;
  logic [AW-1:0]          alloc_reg;
  logic                   alloc_ready;
  logic                   wb_en;
  logic [AW-1:0]          wb_reg;
  logic [WIDTH-1:0]       wb_data;
  logic                   flush;
  logic                   stall;
  logic                   err;

  int n_checks;
  int n_fail;

  logic [WIDTH-1:0] m_reg [NREG];
  int               m_cnt [NREG];
  logic             m_err;
  logic [WIDTH-1:0] exp_q [$];

  decode_regfile_sb #(
    .WIDTH(WIDTH), .NREG(NREG), .NRD(NRD), .MAXINF(MAXINF)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_sel(rd_sel), .rd_en(rd_en), .rd_data(rd_data), .rd_pending(rd_pending),
    .alloc_en(alloc_en), .alloc_reg(alloc_reg), .alloc_ready(alloc_ready),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .flush(flush), .stall(stall), .err(err)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: transaction-level view of the scoreboard
  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_reg[r] = '0;
      m_cnt[r] = 0;
    end
    m_err = 1'b0;
  endtask

  task automatic model_edge();
    if (wb_en) m_reg[wb_reg] = wb_data;
    if (flush) begin
      for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
      if (alloc_en) m_cnt[alloc_reg] = 1;
    end else if (alloc_en && wb_en && alloc_reg == wb_reg) begin
      // issue and retire of the same register cancel out
    end else begin
      if (alloc_en) begin
        if (m_cnt[alloc_reg] == MAXINF) m_err = 1'b1;
        else m_cnt[alloc_reg] = m_cnt[alloc_reg] + 1;
      end
      if (wb_en) begin
        if (m_cnt[wb_reg] == 0) m_err = 1'b1;
        else m_cnt[wb_reg] = m_cnt[wb_reg] - 1;
      end
    end
  endtask

  function automatic logic m_byp(input int sel);
    return BYP && wb_en && (int'(wb_reg) == sel);
  endfunction

  function automatic logic m_pend(input int sel);
    return (m_cnt[sel] != 0) &&
           !(m_byp(sel) && m_cnt[sel] == 1 && !(alloc_en && int'(alloc_reg) == sel));
  endfunction

  function automatic logic [WIDTH-1:0] m_data(input int sel);
    return m_byp(sel) ? wb_data : m_reg[sel];
  endfunction

  // driver tasks
  task automatic idle();
    rd_sel    = '0;
    rd_en     = '0;
    alloc_en  = 1'b0;
    alloc_reg = '0;
    wb_en     = 1'b0;
    wb_reg    = '0;
    wb_data   = '0;
    flush     = 1'b0;
  endtask

  task automatic set_port(input int p, input int r, input logic en);
    rd_sel[p*AW +: AW] = AW'(r);
    rd_en[p]           = en;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_edge();
    #1;
  endtask

  task automatic apply_reset();
    idle();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic alloc_tick(input int r);
    alloc_en  = 1'b1;
    alloc_reg = AW'(r);
    tick();
    alloc_en  = 1'b0;
  endtask

  task automatic wb_tick(input int r, input logic [WIDTH-1:0] d);
    wb_en   = 1'b1;
    wb_reg  = AW'(r);
    wb_data = d;
    tick();
    wb_en   = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    idle();
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++; if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    n_checks++; if (rd_pending !== '0) begin n_fail++; $display("FAIL reset_pending: got %b want 0", rd_pending); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_checks++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alloc_ready: got %b want 1", alloc_ready); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    @(negedge clk);
    rst = 1'b1;
    set_port(0, 5, 1'b1);
    set_port(1, 7, 1'b1);
    #1;
    n_checks++; if (rd_data !== '0 || stall !== 1'b0) begin n_fail++; $display("FAIL reset_all_ports: data %h stall %b want 0/0", rd_data, stall); end
  endtask

  task automatic test_pending_bypass();
    apply_reset();
    alloc_tick(3);
    set_port(0, 3, 1'b1);
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall_c1: got %b want 1", stall); end
    wb_en = 1'b1; wb_reg = 3'd3; wb_data = 16'hBEEF;
    #1;
    if (BYP) begin
      n_checks++; if (rd_data[WIDTH-1:0] !== 16'hBEEF) begin n_fail++; $display("FAIL bypass_data_c2: got %h want beef", rd_data[WIDTH-1:0]); end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL bypass_stall_c2: got %b want 0", stall); end
    end else begin
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL nobyp_stall_c2: got %b want 1", stall); end
    end
    tick();
    wb_en = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_stall_c3: got %b want 0", stall); end
    n_checks++; if (rd_data[WIDTH-1:0] !== 16'hBEEF) begin n_fail++; $display("FAIL raw_data_c3: got %h want beef", rd_data[WIDTH-1:0]); end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int k = 0; k < MAXINF; k++) alloc_tick(5);
    alloc_reg = 3'd5;
    set_port(1, 5, 1'b0);
    #1;
    n_checks++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_ready_full: got %b want 0", alloc_ready); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ovf_err_before: got %b want 0", err); end
    alloc_tick(5);
    #1;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL ovf_err_set: got %b want 1", err); end
    n_checks++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_ready_held: got %b want 0", alloc_ready); end
    wb_tick(5, 16'h0001);
    wb_tick(5, 16'h0002);
    #1;
    n_checks++; if (rd_pending[1] !== 1'b1) begin n_fail++; $display("FAIL ovf_pending_after2: got %b want 1", rd_pending[1]); end
    wb_tick(5, 16'h0003);
    #1;
    n_checks++; if (rd_pending[1] !== 1'b0) begin n_fail++; $display("FAIL ovf_pending_after3: got %b want 0", rd_pending[1]); end
    n_checks++; if (rd_data[WIDTH +: WIDTH] !== 16'h0003) begin n_fail++; $display("FAIL ovf_data: got %h want 0003", rd_data[WIDTH +: WIDTH]); end
    n_checks++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_ready_drained: got %b want 1", alloc_ready); end
  endtask

  task automatic test_same_cycle();
    apply_reset();
    alloc_tick(2);
    alloc_en = 1'b1; alloc_reg = 3'd2;
    wb_en = 1'b1; wb_reg = 3'd2; wb_data = 16'h1234;
    set_port(0, 2, 1'b1);
    #1;
    n_checks++; if (rd_pending[0] !== 1'b1) begin n_fail++; $display("FAIL same_pending_now: got %b want 1", rd_pending[0]); end
    tick();
    idle();
    set_port(0, 2, 1'b1);
    #1;
    n_checks++; if (rd_pending[0] !== 1'b1) begin n_fail++; $display("FAIL same_pending_next: got %b want 1", rd_pending[0]); end
    n_checks++; if (rd_data[WIDTH-1:0] !== 16'h1234) begin n_fail++; $display("FAIL same_data: got %h want 1234", rd_data[WIDTH-1:0]); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL same_err: got %b want 0", err); end
  endtask

  task automatic test_flush();
    apply_reset();
    alloc_tick(1);
    alloc_tick(4);
    alloc_tick(6);
    flush = 1'b1;
    alloc_tick(7);
    flush = 1'b0;
    set_port(0, 1, 1'b1);
    set_port(1, 4, 1'b1);
    #1;
    n_checks++; if (rd_pending !== 2'b00) begin n_fail++; $display("FAIL flush_r1_r4: got %b want 00", rd_pending); end
    set_port(0, 6, 1'b1);
    set_port(1, 7, 1'b1);
    #1;
    n_checks++; if (rd_pending !== 2'b10) begin n_fail++; $display("FAIL flush_r6_r7: got %b want 10", rd_pending); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL flush_err_clean: got %b want 0", err); end
    wb_tick(1, 16'h5555);
    #1;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL flush_underflow_err: got %b want 1", err); end
  endtask

  task automatic test_rd_en_and_async_reset();
    apply_reset();
    alloc_tick(4);
    wb_tick(4, 16'hA5A5);
    alloc_tick(3);
    set_port(0, 3, 1'b0);
    set_port(1, 4, 1'b1);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rden_stall_off: got %b want 0", stall); end
    n_checks++; if (rd_pending[0] !== 1'b1) begin n_fail++; $display("FAIL rden_pending: got %b want 1", rd_pending[0]); end
    n_checks++; if (rd_data[WIDTH +: WIDTH] !== 16'hA5A5) begin n_fail++; $display("FAIL rden_data: got %h want a5a5", rd_data[WIDTH +: WIDTH]); end
    set_port(0, 3, 1'b1);
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rden_stall_on: got %b want 1", stall); end
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++; if (rd_data !== '0) begin n_fail++; $display("FAIL async_rst_data: got %h want 0", rd_data); end
    n_checks++; if (rd_pending !== '0 || stall !== 1'b0) begin n_fail++; $display("FAIL async_rst_pending: pend %b stall %b want 0/0", rd_pending, stall); end
    n_checks++; if (alloc_ready !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL async_rst_ready_err: ready %b err %b want 1/0", alloc_ready, err); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] e;
    logic [NRD-1:0]   ep;
    logic             es;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      idle();
      for (int p = 0; p < NRD; p++) set_port(p, $urandom_range(0, NREG-1), 1'($urandom_range(0, 1)));
      alloc_reg = AW'($urandom_range(0, NREG-1));
      alloc_en  = ($urandom_range(0, 1) == 1) &&
                  (m_cnt[alloc_reg] < MAXINF || $urandom_range(0, 15) == 0);
      wb_reg    = AW'($urandom_range(0, NREG-1));
      wb_en     = ($urandom_range(0, 1) == 1) &&
                  (m_cnt[wb_reg] > 0 || $urandom_range(0, 31) == 0);
      wb_data   = WIDTH'($urandom);
      flush     = ($urandom_range(0, 31) == 0);
      #1;
      for (int p = 0; p < NRD; p++) exp_q.push_back(m_data(int'(rd_sel[p*AW +: AW])));
      es = 1'b0;
      for (int p = 0; p < NRD; p++) begin
        ep[p] = m_pend(int'(rd_sel[p*AW +: AW]));
        es    = es | (rd_en[p] & ep[p]);
      end
      for (int p = 0; p < NRD; p++) begin
        e = exp_q.pop_front();
        n_checks++; if (rd_data[p*WIDTH +: WIDTH] !== e) begin n_fail++; $display("FAIL rand_data c%0d p%0d: got %h want %h", c, p, rd_data[p*WIDTH +: WIDTH], e); end
      end
      n_checks++; if (rd_pending !== ep) begin n_fail++; $display("FAIL rand_pending c%0d: got %b want %b", c, rd_pending, ep); end
      n_checks++; if (stall !== es) begin n_fail++; $display("FAIL rand_stall c%0d: got %b want %b", c, stall, es); end
      n_checks++; if (alloc_ready !== (m_cnt[alloc_reg] < MAXINF)) begin n_fail++; $display("FAIL rand_alloc_ready c%0d: got %b want %b", c, alloc_ready, (m_cnt[alloc_reg] < MAXINF)); end
      n_checks++; if (err !== m_err) begin n_fail++; $display("FAIL rand_err c%0d: got %b want %b", c, err, m_err); end
      tick();
    end
  endtask

  // sequence and final report
  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_pending_bypass();
    test_overflow();
    test_same_cycle();
    test_flush();
    test_rd_en_and_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
